// File: rtl/divider64.sv
// -----------------------------------------------------------------------------
// divider64 -- iterative restoring integer divider for the EXE stage.
//
// Computes quotient and remainder of a 64-bit (or 32-bit word) division,
// signed or unsigned, one quotient bit per clock. The FSM runs
// IDLE -> BUSY -> DONE -> IDLE.
//
// Timing: a request first seen in cycle 0 produces div_ready in cycle K+1,
// where K = 64 for full-width ops and K = 32 for word ops.
//
// Build option:
//   DIV_FAST_ZERO_EN - when defined, a zero divisor (at the operation width)
//                      leaves BUSY after one cycle, so div_ready arrives in
//                      cycle 2. Result values are the same either way.
//
// Ports:
//   clk          in   1    single clock, rising edge
//   rst          in   1    synchronous, active-high reset
//   div_valid    in   1    request, held by EXE until div_ready
//   div_32       in   1    word op (DIVW/REMW), operands are bits [31:0]
//   div_signed   in   1    1 = signed (DIV/REM), 0 = unsigned
//   div_dividend in   64   dividend (rs1)
//   div_divisor  in   64   divisor (rs2)
//   div_ready    out  1    one-cycle completion pulse (DONE state)
//   div_result   out  128  [63:0] quotient, [127:64] remainder
//   div_busy     out  1    high while in BUSY or DONE
//
// Only DIV_XLEN = 64 is supported.
// -----------------------------------------------------------------------------
module divider64 #(
  parameter int DIV_XLEN = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    div_valid,
  input  logic                    div_32,
  input  logic                    div_signed,
  input  logic [DIV_XLEN-1:0]     div_dividend,
  input  logic [DIV_XLEN-1:0]     div_divisor,
  output logic                    div_ready,
  output logic [2*DIV_XLEN-1:0]   div_result,
  output logic                    div_busy
);

  localparam int HALF = DIV_XLEN / 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Final sign fix-up, divide-by-zero override and word-op sign extension.
  // Signed overflow (most-negative / -1) needs no special case: both signs
  // are negative so the magnitude quotient 2^(N-1) passes through unchanged,
  // which is the dividend itself, and the remainder is zero.
  function automatic logic [2*DIV_XLEN-1:0] fix_result(
    input logic [DIV_XLEN-1:0] quo_mag,
    input logic [DIV_XLEN-1:0] rem_mag,
    input logic [DIV_XLEN-1:0] dvd,
    input logic                w32,
    input logic                neg_quo,
    input logic                neg_rem,
    input logic                dvs_zero
  );
    logic [DIV_XLEN-1:0] q;
    logic [DIV_XLEN-1:0] r;
    q = neg_quo ? -quo_mag : quo_mag;
    r = neg_rem ? -rem_mag : rem_mag;
    if (dvs_zero) begin
      q = '1;
      r = dvd;
    end
    if (w32) begin
      q = {{HALF{q[HALF-1]}}, q[HALF-1:0]};
      r = {{HALF{r[HALF-1]}}, r[HALF-1:0]};
    end
    return {r, q};
  endfunction

  logic [1:0]              state_q,  state_d;
  logic [6:0]              cnt_q,    cnt_d;
  logic                    w32_q,    w32_d;
  logic                    negq_q,   negq_d;
  logic                    negr_q,   negr_d;
  logic                    zero_q,   zero_d;
  logic [DIV_XLEN-1:0]     dvd_q,    dvd_d;
  logic [DIV_XLEN-1:0]     dvs_q,    dvs_d;
  logic [DIV_XLEN-1:0]     rem_q,    rem_d;
  logic [DIV_XLEN-1:0]     quo_q,    quo_d;
  logic [2*DIV_XLEN-1:0]   result_q, result_d;

  // Operand conditioning at capture time.
  logic                    a_neg;
  logic                    b_neg;
  logic [DIV_XLEN-1:0]     a_w;
  logic [DIV_XLEN-1:0]     b_w;
  logic [DIV_XLEN-1:0]     a_mag;
  logic [DIV_XLEN-1:0]     b_mag;
  logic                    b_zero;

  assign a_neg  = div_signed & (div_32 ? div_dividend[HALF-1] : div_dividend[DIV_XLEN-1]);
  assign b_neg  = div_signed & (div_32 ? div_divisor[HALF-1]  : div_divisor[DIV_XLEN-1]);
  assign a_w    = div_32 ? {{HALF{a_neg}}, div_dividend[HALF-1:0]} : div_dividend;
  assign b_w    = div_32 ? {{HALF{b_neg}}, div_divisor[HALF-1:0]}  : div_divisor;
  assign a_mag  = a_neg ? -a_w : a_w;
  assign b_mag  = b_neg ? -b_w : b_w;
  assign b_zero = div_32 ? (div_divisor[HALF-1:0] == '0) : (div_divisor == '0);

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor if it fits, shift the outcome into the
  // quotient. The partial remainder is always below the divisor, so the
  // shifted value needs one extra bit but the result fits back in N bits.
  logic [DIV_XLEN:0]       rem_sh;
  logic [DIV_XLEN:0]       rem_sub;
  logic                    step_ge;
  logic [DIV_XLEN-1:0]     rem_nx;
  logic [DIV_XLEN-1:0]     quo_nx;
  logic                    last_step;
  logic                    fast_exit;

  assign rem_sh    = {rem_q, quo_q[DIV_XLEN-1]};
  assign rem_sub   = rem_sh - {1'b0, dvs_q};
  assign step_ge   = (rem_sh >= {1'b0, dvs_q});
  assign rem_nx    = step_ge ? rem_sub[DIV_XLEN-1:0] : rem_sh[DIV_XLEN-1:0];
  assign quo_nx    = {quo_q[DIV_XLEN-2:0], step_ge};
  assign last_step = (cnt_q == (w32_q ? 7'd31 : 7'd63));

`ifdef DIV_FAST_ZERO_EN
  assign fast_exit = zero_q;
`else
  assign fast_exit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w32_d    = w32_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    zero_d   = zero_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (div_valid) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          w32_d   = div_32;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          zero_d  = b_zero;
          dvd_d   = div_dividend;
          dvs_d   = b_mag;
          rem_d   = '0;
          // Word ops are left-aligned so the same MSB-first shift serves
          // both widths; after 32 steps the quotient sits in [31:0].
          quo_d   = div_32 ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
        end
      end

      S_BUSY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 7'd1;
        if (last_step || fast_exit) begin
          state_d  = S_DONE;
          result_d = fix_result(quo_nx, rem_nx, dvd_q, w32_q, negq_q, negr_q, zero_q);
        end
      end

      // Any request seen here is deliberately ignored; it is picked up from
      // IDLE on the next cycle.
      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      w32_q    <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      zero_q   <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w32_q    <= w32_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      zero_q   <= zero_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
    end
  end

  // DONE lasts exactly one cycle, so decoding it gives the ready pulse.
  assign div_ready  = (state_q == S_DONE);
  assign div_busy   = (state_q != S_IDLE);
  assign div_result = result_q;

endmodule

// File: doc/divider64.md
DIVIDER64 -- requirements
Module: divider64

Interface
REQ-001 SHALL have parameter DIV_XLEN, default 64, operand width; only 64 is supported.
REQ-002 SHALL have port clk  input  1  single clock, all state on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port div_valid  input  1  request; held high by the EXE stage until div_ready is seen.
REQ-005 SHALL have port div_32  input  1  word op (DIVW/REMW); operands are the low 32 bits.
REQ-006 SHALL have port div_signed  input  1  1 = signed (DIV/REM), 0 = unsigned.
REQ-007 SHALL have port div_dividend  input  64  dividend, the forwarded rs1 value.
REQ-008 SHALL have port div_divisor  input  64  divisor, the forwarded rs2 value.
REQ-009 SHALL have port div_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port div_result  output  128  [63:0] quotient, [127:64] remainder.
REQ-011 SHALL have port div_busy  output  1  high while in BUSY or DONE.

Function
REQ-012 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-013 In IDLE with div_valid=1, it SHALL capture div_32, div_signed, both operands, and the operand signs, then go to BUSY; later operand changes are ignored.
REQ-014 BUSY SHALL run one restoring shift/subtract step per cycle on operand magnitudes: K=64 steps, or K=32 when div_32=1.
REQ-015 Latency: div_valid first high in cycle 0 SHALL give div_ready=1 in cycle K+1, in the DONE state only, for exactly one cycle.
REQ-016 Sign fix-up: the quotient SHALL be negated when the operand signs differ; the remainder SHALL take the dividend's sign.
REQ-017 Divisor zero SHALL give quotient all-ones and remainder equal to the dividend, at the operation width.
REQ-018 Signed overflow (most-negative / -1) SHALL give quotient equal to the dividend and remainder 0.
REQ-019 When div_32=1: quotient in [31:0] and remainder in [95:64]; [63:32] and [127:96] SHALL be sign-extensions of bit 31 and bit 95.
REQ-020 div_result SHALL be registered on entry to DONE and held stable until the next IDLE->BUSY transition.
REQ-021 div_valid sampled in DONE SHALL be ignored; a back-to-back request SHALL start from IDLE on the following cycle.
REQ-022 div_valid dropping during BUSY SHALL NOT abort the operation; DONE and the ready pulse still occur.

Reset
REQ-023 rst=1 SHALL force IDLE with div_ready=0, div_busy=0, div_result=0, step counter 0, and working registers 0.
REQ-024 rst asserted mid-operation SHALL discard the operation, with no div_ready pulse afterwards.

Configuration
REQ-025 With macro DIV_FAST_ZERO_EN defined, a zero divisor (at the operation width) SHALL skip iteration: BUSY lasts 1 cycle and div_ready arrives in cycle 2.
REQ-026 Without DIV_FAST_ZERO_EN, a zero divisor SHALL take the full K+1 latency.
REQ-027 Result values SHALL be identical with or without DIV_FAST_ZERO_EN.

Verification
REQ-028 64-bit signed 100 / -7 -> div_ready in cycle 65; quotient 0xFFFFFFFFFFFFFFF2 (-14); remainder 2.
REQ-029 div_32 signed 0x80000000 / 0xFFFFFFFF -> ready in cycle 33; [63:0]=0xFFFFFFFF80000000; [127:64]=0.
REQ-030 Unsigned 64-bit 0x10 / 0 -> quotient 0xFFFFFFFFFFFFFFFF, remainder 0x10; ready in cycle 2 with DIV_FAST_ZERO_EN, cycle 65 without.
REQ-031 Back-to-back requests (valid held high through ready), -9/2 then 9/-2 -> results (-4,-1) then (-4,1); the second ready arrives 66 cycles after the first.
REQ-032 rst pulsed at BUSY step 10 -> div_busy=0 the next cycle, no div_ready pulse, and div_result=0.
REQ-033 Operands changed during BUSY -> result reflects the captured values; div_result is unchanged while IDLE.
